// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, types and FSM states for the neural-network result path
package nn_pkg;
  localparam int N_CLASSES = 10;
  localparam int PROB_W = 16;
  typedef logic [PROB_W-1:0] prob_t;
  typedef logic [3:0] class_t;
  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
endpackage

// File: rtl/stability_counter.sv
// stability_counter: counts consecutive confident results for one class and flags a steady prediction
module stability_counter
  import nn_pkg::*;
#(
  parameter int STABLE_COUNT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   upd,
  input  logic   conf,
  input  class_t cls,
  output logic   stable,
  output class_t stable_class
);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  class_t prev;
  always_comb begin
    cnt_nxt = !conf ? '0 :
              cls != prev ? CW'(1) :
              cnt == CW'(STABLE_COUNT) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      prev <= '0;
      stable <= 1'b0;
      stable_class <= '0;
    end else if (upd) begin
      cnt <= cnt_nxt;
      if (conf) prev <= cls;
      stable <= conf && cnt_nxt == CW'(STABLE_COUNT);
      if (conf && cnt_nxt == CW'(STABLE_COUNT)) stable_class <= cls;
    end
  end
endmodule

// File: rtl/prediction_filter.sv
// prediction_filter: snapshots a probability vector, scans it one class per cycle for best/runner-up,
// and feeds a stability filter so downstream display logic sees a steady prediction
module prediction_filter
  import nn_pkg::*;
#(
  parameter int    STABLE_COUNT = 4,
  parameter prob_t MARGIN_MIN   = 16'h0100
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   Valid,
  input  prob_t  Probability [N_CLASSES],
  output logic   Busy,
  output logic   Done,
  output class_t Argmax,
  output class_t Runner_up,
  output prob_t  Max_prob,
  output prob_t  Margin,
  output logic   Stable,
  output class_t Stable_class,
  output logic   Overrun
);
  state_t state, state_nxt;
  prob_t snap [N_CLASSES];
  class_t idx, best_idx, sec_idx;
  prob_t best_val, sec_val, cur, diff;
  logic seed;
  assign cur = snap[idx];
  assign diff = best_val - sec_val;
  assign Busy = state != IDLE;
  always_comb begin
    state_nxt = state == IDLE ? (Valid ? SCAN : IDLE) :
                state == SCAN ? (idx == class_t'(N_CLASSES - 1) ? FINISH : SCAN) : IDLE;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      snap <= '{default: '0};
      idx <= '0;
      best_idx <= '0;
      best_val <= '0;
      sec_idx <= '0;
      sec_val <= '0;
      seed <= 1'b0;
      Done <= 1'b0;
      Argmax <= '0;
      Runner_up <= '0;
      Max_prob <= '0;
      Margin <= '0;
      Overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      Done <= 1'b0;
      if (Valid && state != IDLE) Overrun <= 1'b1;
      if (state == IDLE && Valid) begin
        snap <= Probability;
        best_idx <= '0;
        best_val <= Probability[0];
        sec_idx <= '0;
        sec_val <= '0;
        seed <= 1'b1;
        idx <= class_t'(1);
      end else if (state == SCAN) begin
        // strict compares keep the lower index on ties; the seed slot is always displaced
        if (cur > best_val) begin
          sec_idx <= best_idx;
          sec_val <= best_val;
          best_idx <= idx;
          best_val <= cur;
          seed <= 1'b0;
        end else if (cur > sec_val || seed) begin
          sec_idx <= idx;
          sec_val <= cur;
          seed <= 1'b0;
        end
        idx <= idx + 1'b1;
      end else if (state == FINISH) begin
        Argmax <= best_idx;
        Runner_up <= sec_idx;
        Max_prob <= best_val;
        Margin <= diff;
        Done <= 1'b1;
      end
    end
  end
  stability_counter #(.STABLE_COUNT(STABLE_COUNT)) u_stab (
    .clk(Clk),
    .rst_n(Reset_n),
    .upd(state == FINISH),
    .conf(diff >= MARGIN_MIN),
    .cls(best_idx),
    .stable(Stable),
    .stable_class(Stable_class)
  );
endmodule

// File: tb/tb_prediction_filter.sv
// tb_prediction_filter: directed vector table plus overrun and mid-scan reset sequences
module tb_prediction_filter;
  typedef struct packed {
    logic [9:0][15:0] p;
    logic [3:0] am;
    logic [3:0] ru;
    logic [15:0] mp;
    logic [15:0] mg;
    logic st;
    logic [3:0] sc;
  } vec_t;
  logic Clk, Reset_n, Valid, Busy, Done, Stable, Overrun;
  logic [15:0] Probability [10];
  logic [3:0] Argmax, Runner_up, Stable_class;
  logic [15:0] Max_prob, Margin;
  int nvec, nmis;
  vec_t tbl [15];
  prediction_filter dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .Probability(Probability),
    .Busy(Busy), .Done(Done), .Argmax(Argmax), .Runner_up(Runner_up),
    .Max_prob(Max_prob), .Margin(Margin), .Stable(Stable),
    .Stable_class(Stable_class), .Overrun(Overrun)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  function automatic logic [9:0][15:0] pv(int a, logic [15:0] va, int b, logic [15:0] vb,
                                          int c, logic [15:0] vc);
    logic [9:0][15:0] r;
    r = '0;
    r[a] = va;
    r[b] = vb;
    r[c] = vc;
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [9:0][15:0] p);
    @(posedge Clk); #1;
    Valid = 1'b1;
    for (int i = 0; i < 10; i++) Probability[i] = p[i];
    @(posedge Clk); #1;
    Valid = 1'b0;
    for (int i = 0; i < 10; i++) Probability[i] = 16'($urandom);
  endtask
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!Done && lat < 30) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask
  task automatic chk_result(input string tag, input vec_t v, input int lat);
    chk({tag, " latency"}, 64'(lat), 64'd11);
    chk({tag, " argmax"}, 64'(Argmax), 64'(v.am));
    chk({tag, " runner_up"}, 64'(Runner_up), 64'(v.ru));
    chk({tag, " max_prob"}, 64'(Max_prob), 64'(v.mp));
    chk({tag, " margin"}, 64'(Margin), 64'(v.mg));
    chk({tag, " stable"}, 64'(Stable), 64'(v.st));
    chk({tag, " stable_class"}, 64'(Stable_class), 64'(v.sc));
  endtask
  initial begin
    int lat, seen;
    vec_t t1;
    nvec = 0;
    nmis = 0;
    Valid = 1'b0;
    for (int i = 0; i < 10; i++) Probability[i] = '0;
    t1 = '{pv(0, 16'h0010, 1, 16'h0200, 2, 16'h0050), 4'd1, 4'd2, 16'h0200, 16'h01B0, 1'b0, 4'd0};
    tbl[0] = t1;
    tbl[1] = '{pv(3, 16'h0400, 7, 16'h0400, 9, 16'h0000), 4'd3, 4'd7, 16'h0400, 16'h0000, 1'b0, 4'd0};
    for (int i = 2; i < 5; i++)
      tbl[i] = '{pv(5, 16'h0300, 9, 16'h0000, 8, 16'h0000), 4'd5, 4'd0, 16'h0300, 16'h0300, 1'b0, 4'd0};
    tbl[5] = '{pv(5, 16'h0300, 9, 16'h0000, 8, 16'h0000), 4'd5, 4'd0, 16'h0300, 16'h0300, 1'b1, 4'd5};
    tbl[6] = '{pv(2, 16'h0300, 9, 16'h0000, 8, 16'h0000), 4'd2, 4'd0, 16'h0300, 16'h0300, 1'b0, 4'd5};
    for (int i = 7; i < 14; i++)
      tbl[i] = '{pv(5, 16'h0300, 9, 16'h0000, 8, 16'h0000), 4'd5, 4'd0, 16'h0300, 16'h0300, 1'b0, 4'd5};
    tbl[10] = '{pv(5, 16'h01FF, 9, 16'h0100, 8, 16'h0000), 4'd5, 4'd9, 16'h01FF, 16'h00FF, 1'b0, 4'd5};
    tbl[14] = '{pv(5, 16'h0180, 9, 16'h0080, 8, 16'h0000), 4'd5, 4'd9, 16'h0180, 16'h0100, 1'b1, 4'd5};
    Reset_n = 1'b0;
    #3;
    chk("reset outputs", 64'({Busy, Done, Argmax, Runner_up, Max_prob, Margin, Stable, Stable_class, Overrun}), 64'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      send(tbl[k].p);
      chk($sformatf("v%0d busy", k), 64'(Busy), 64'd1);
      wait_done(1, lat);
      chk_result($sformatf("v%0d", k), tbl[k], lat);
      chk($sformatf("v%0d overrun", k), 64'(Overrun), 64'd0);
      @(posedge Clk); #1;
      chk($sformatf("v%0d done pulse", k), 64'({Done, Busy}), 64'd0);
    end
    // Valid again four cycles after the first: must be dropped and flagged
    send(t1.p);
    repeat (3) begin @(posedge Clk); #1; end
    Valid = 1'b1;
    for (int i = 0; i < 10; i++) Probability[i] = tbl[1].p[i];
    @(posedge Clk); #1;
    Valid = 1'b0;
    wait_done(5, lat);
    chk("overrun latency", 64'(lat), 64'd11);
    chk("overrun argmax", 64'(Argmax), 64'd1);
    chk("overrun runner_up", 64'(Runner_up), 64'd2);
    chk("overrun margin", 64'(Margin), 64'h01B0);
    chk("overrun flag", 64'(Overrun), 64'd1);
    send(tbl[1].p);
    wait_done(1, lat);
    chk("overrun sticky", 64'(Overrun), 64'd1);
    chk("post overrun argmax", 64'(Argmax), 64'd3);
    // reset in the middle of a scan
    send(t1.p);
    repeat (4) begin @(posedge Clk); #1; end
    Reset_n = 1'b0;
    #2;
    chk("midscan reset outputs", 64'({Busy, Done, Argmax, Runner_up, Max_prob, Margin, Stable, Stable_class, Overrun}), 64'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge Clk); #1;
      if (Done) seen++;
    end
    chk("no done after reset", 64'(seen), 64'd0);
    send(t1.p);
    wait_done(1, lat);
    chk_result("after reset", t1, lat);
    chk("after reset overrun", 64'(Overrun), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/prediction_filter.md
Name: prediction_filter

Overview:
- Sits directly downstream of neural_network.
- Captures the 10-entry Probability vector when the network signals a result, then scans it sequentially, one class per cycle, to find the best and runner-up classes and the margin between them.
- Applies a temporal stability filter across successive results so that downstream display/LED logic shows a steady prediction instead of per-frame flicker.

Parameters:
- N_CLASSES, 10, number of class scores scanned.
- PROB_W, 16, width of each unsigned fixed-point probability.
- STABLE_COUNT, 4, consecutive agreeing confident results needed to assert Stable; must be >= 1.
- MARGIN_MIN, 16'h0100, minimum (best - runner-up) for a result to count as confident.

Ports:
- Clk  in  1  system clock (50 MHz domain).
- Reset_n  in  1  asynchronous, active-low reset.
- Valid  in  1  one-cycle pulse from neural_network: Probability is valid this cycle.
- Probability  in  N_CLASSES x PROB_W  unpacked array of class scores.
- Busy  out  1  high while a captured vector is being processed.
- Done  out  1  one-cycle pulse: result outputs updated this cycle.
- Argmax  out  4  best class index.
- Runner_up  out  4  second-best class index.
- Max_prob  out  PROB_W  score of Argmax.
- Margin  out  PROB_W  Max_prob minus runner-up score.
- Stable  out  1  filtered prediction is valid.
- Stable_class  out  4  last class that reached stability.
- Overrun  out  1  sticky: a Valid arrived while Busy.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All outputs and internal registers go to 0.
  - FSM goes to IDLE.
  - Applies mid-scan as well: the scan is abandoned and Done is not emitted.
- FSM states: IDLE, SCAN, FINISH.
- IDLE:
  - On Valid, snapshot all N_CLASSES scores into an internal array.
  - Seed best = (0, p[0]) and second = (0, 0); set idx = 1; go to SCAN.
  - Busy rises in the cycle after Valid.
- SCAN: one score per cycle, idx = 1..N_CLASSES-1. For p = snap[idx]:
  - If p > best_val: second <= best; best <= (idx, p).
  - Else if p > second_val, or second is still the seed: second <= (idx, p).
  - Comparisons are unsigned and strict, so on ties the lower index wins.
  - After idx = N_CLASSES-1, go to FINISH.
- FINISH (one cycle):
  - Register Argmax, Runner_up, Max_prob, and Margin = best_val - second_val (never negative).
  - Update the filter; pulse Done; clear Busy; return to IDLE.
- Latency: Valid at cycle T gives Done at T + N_CLASSES + 1 (T+11 by default).
  - A new Valid is accepted in the cycle after Done, i.e. back-to-back throughput is one vector per N_CLASSES+1 cycles.
- Valid while Busy (including in the FINISH cycle):
  - Ignored; Overrun set sticky until reset.
  - The snapshot is not disturbed.
- Filter, evaluated in FINISH with a counter cnt of width clog2(STABLE_COUNT+1), saturating at STABLE_COUNT:
  - Margin < MARGIN_MIN: cnt <= 0; Stable <= 0.
  - Confident and Argmax == previous confident argmax: cnt <= min(cnt+1, STABLE_COUNT).
  - Confident and different class: cnt <= 1; previous <= Argmax.
  - When cnt reaches STABLE_COUNT: Stable <= 1; Stable_class <= Argmax.
  - A confident result for a new class drops Stable to 0 but holds Stable_class until the new class stabilises.
- Probability may change freely after the Valid cycle; only the snapshot is used.
- The previous confident argmax is reset to 0 with cnt = 0. The first confident result therefore always loads cnt = 1, even for class 0.

Decomposition:
- Shared package nn_pkg holds:
  - N_CLASSES, PROB_W;
  - typedef prob_t (logic [PROB_W-1:0]);
  - typedef class_t (logic [3:0]);
  - the FSM state enum.
- Natural sub-module: stability_counter. It takes the per-result class and confident flag with an update strobe, and owns cnt, the previous class, Stable and Stable_class.
- The scan/compare datapath stays in prediction_filter.

Test Plan:
- Reset then Valid with p = {0x0010, 0x0200, 0x0050, 0 ...} -> Done at T+11; Argmax = 1, Runner_up = 2, Max_prob = 0x0200, Margin = 0x01B0.
- Tie p[3] = p[7] = 0x0400, all others 0 -> Argmax = 3, Runner_up = 7, Margin = 0.
- Four consecutive confident results, class 5, margin 0x0300 -> Stable rises with the 4th Done; Stable_class = 5. A 5th result for class 2 -> Stable = 0, Stable_class holds 5.
- Confident class 5 results x3, then one with margin 0x00FF, then class 5 x3 -> Stable stays 0 throughout (counter cleared by the low-margin result).
- Valid pulses at T and T+4 -> single Done at T+11 reflecting the T vector; Overrun = 1 and remains set.
- Reset_n low at T+5 mid-scan -> no Done; all outputs 0; next Valid processed normally with 11-cycle latency.
